glitch_response_monitor: RTL and testbench

// - Observing end of the glitch rig: watches the glitch drive line (low = glitch active) and
//   the AVR target's heartbeat and success pins, then classifies each glitch attempt.
// - Sits beside the glitch pulse generator on the iCEstick; its result feeds LEDs/logging.
// - Measures each glitch pulse width and opens a fixed observation window after it.

---
 rtl/glitch_response_monitor.sv | 175 +++++++++++++++++
 tb/tb_glitch_response_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_response_monitor.sv
// ============================================================================
// glitch_response_monitor
//   Measures each glitch pulse width, watches the target's heartbeat and
//   success pins over a fixed observation window and classifies the attempt.
//   Optional macro: GLITCH_MON_STICKY_EN (freeze on first SUCCESS).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module glitch_response_monitor #(
  parameter int OBS_CYCLES = 12_000_000,
  parameter int HB_MIN     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        glitch_in,
  input  logic        target_hb,
  input  logic        target_ok,
  output logic        result_valid,
  output logic [1:0]  result_code,
  output logic [15:0] pulse_width,
  output logic [15:0] attempt_count,
`ifdef GLITCH_MON_STICKY_EN
  output logic        success_latched,
`endif
  output logic        busy
);

  localparam int              c_WIN_W    = $clog2(OBS_CYCLES + 1);
  localparam logic [c_WIN_W-1:0] c_OBS_LAST = c_WIN_W'(OBS_CYCLES);
  localparam logic [7:0]      c_HB_MIN   = 8'(HB_MIN);

  localparam logic [1:0] c_CODE_NORMAL   = 2'b00;
  localparam logic [1:0] c_CODE_DEGRADED = 2'b01;
  localparam logic [1:0] c_CODE_MUTE     = 2'b10;
  localparam logic [1:0] c_CODE_SUCCESS  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_OBSERVE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_gl_s1, r_gl_s2, r_gl_d;
  logic                 r_hb_s1, r_hb_s2, r_hb_d;
  logic                 r_ok_s1, r_ok_s2;
  logic [15:0]          r_width;
  logic [15:0]          r_pw_hold;
  logic [c_WIN_W-1:0]   r_win;
  logic [7:0]           r_edges;
  logic                 r_ok;
  logic                 w_sticky;

  logic                 w_gl_fall, w_gl_rise, w_hb_edge;
  logic [c_WIN_W-1:0]   w_win_inc;
  logic [7:0]           w_edges_next;
  logic                 w_ok_next;
  logic [1:0]           w_code;
  logic                 w_window_end;

  assign w_gl_fall = r_gl_d & ~r_gl_s2;
  assign w_gl_rise = ~r_gl_d & r_gl_s2;
  assign w_hb_edge = r_hb_d ^ r_hb_s2;

  // The last observation cycle's heartbeat/ok samples still count toward the result.
  assign w_win_inc    = r_win + 1'b1;
  assign w_edges_next = (w_hb_edge && (r_edges != 8'hFF)) ? r_edges + 8'd1 : r_edges;
  assign w_ok_next    = r_ok | r_ok_s2;
  assign w_window_end = (w_win_inc == c_OBS_LAST) || w_gl_fall;

  always_comb begin
    w_code = c_CODE_DEGRADED;
    if (w_ok_next)
      w_code = c_CODE_SUCCESS;
    else if (w_edges_next >= c_HB_MIN)
      w_code = c_CODE_NORMAL;
    else if (w_edges_next == 8'd0)
      w_code = c_CODE_MUTE;
  end

`ifdef GLITCH_MON_STICKY_EN
  logic r_sticky;
  assign w_sticky        = r_sticky;
  assign success_latched = r_sticky;
`else
  assign w_sticky = 1'b0;
`endif

  assign busy = (r_state == S_PULSE) || (r_state == S_OBSERVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_gl_s1       <= 1'b1;
      r_gl_s2       <= 1'b1;
      r_gl_d        <= 1'b1;
      r_hb_s1       <= 1'b0;
      r_hb_s2       <= 1'b0;
      r_hb_d        <= 1'b0;
      r_ok_s1       <= 1'b0;
      r_ok_s2       <= 1'b0;
      r_width       <= 16'd0;
      r_pw_hold     <= 16'd0;
      r_win         <= '0;
      r_edges       <= 8'd0;
      r_ok          <= 1'b0;
      result_valid  <= 1'b0;
      result_code   <= 2'b00;
      pulse_width   <= 16'd0;
      attempt_count <= 16'd0;
`ifdef GLITCH_MON_STICKY_EN
      r_sticky      <= 1'b0;
`endif
    end else begin
      r_gl_s1 <= glitch_in;
      r_gl_s2 <= r_gl_s1;
      r_gl_d  <= r_gl_s2;
      r_hb_s1 <= target_hb;
      r_hb_s2 <= r_hb_s1;
      r_hb_d  <= r_hb_s2;
      r_ok_s1 <= target_ok;
      r_ok_s2 <= r_ok_s1;

      if (w_gl_fall)
        r_width <= 16'd1;
      else if (!r_gl_s2 && (r_width != 16'hFFFF))
        r_width <= r_width + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_gl_fall && !w_sticky)
            r_state <= S_PULSE;
        end
        S_PULSE: begin
          if (w_gl_rise) begin
            r_state   <= S_OBSERVE;
            r_pw_hold <= r_width;
            r_win     <= '0;
            r_edges   <= 8'd0;
            r_ok      <= 1'b0;
          end
        end
        S_OBSERVE: begin
          r_win   <= w_win_inc;
          r_edges <= w_edges_next;
          r_ok    <= w_ok_next;
          if (w_window_end) begin
            r_state       <= S_REPORT;
            result_valid  <= 1'b1;
            result_code   <= w_code;
            pulse_width   <= r_pw_hold;
            attempt_count <= attempt_count + 16'd1;
`ifdef GLITCH_MON_STICKY_EN
            if (w_code == c_CODE_SUCCESS)
              r_sticky <= 1'b1;
`endif
          end
        end
        default: begin
          result_valid <= 1'b0;
          // A new pulse already under way goes straight back to measuring it.
          if (!r_gl_s2 && !w_sticky)
            r_state <= S_PULSE;
          else
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glitch_response_monitor.sv
// ============================================================================
// tb_glitch_response_monitor
//   Directed stimulus with a result scoreboard for glitch_response_monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_glitch_response_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        glitch_in;
  logic        target_hb;
  logic        target_ok;
  logic        result_valid;
  logic [1:0]  result_code;
  logic [15:0] pulse_width;
  logic [15:0] attempt_count;
  logic        busy;
`ifdef GLITCH_MON_STICKY_EN
  logic        success_latched;
`endif

  logic hb_auto;
  logic hb_manual;
  logic hb_en;
  assign target_hb = hb_auto ^ hb_manual;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  code;
    logic [15:0] pw;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  glitch_response_monitor #(.OBS_CYCLES(100), .HB_MIN(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .glitch_in     (glitch_in),
    .target_hb     (target_hb),
    .target_ok     (target_ok),
    .result_valid  (result_valid),
    .result_code   (result_code),
    .pulse_width   (pulse_width),
    .attempt_count (attempt_count),
`ifdef GLITCH_MON_STICKY_EN
    .success_latched (success_latched),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    glitch_in = 1'b0;
    repeat (w) @(negedge clk);
    glitch_in = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int cyc);
    cyc = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (result_valid) return;
    end
    cyc = -1;
  endtask

  task automatic push(input logic [1:0] code, input logic [15:0] pw, input logic [15:0] cnt);
    exp_t e;
    e.code = code;
    e.pw   = pw;
    e.cnt  = cnt;
    sb_q.push_back(e);
  endtask

  // Heartbeat source: toggles every 10 cycles while enabled.
  initial begin
    hb_auto = 1'b0;
    forever begin
      repeat (10) @(negedge clk);
      if (hb_en) hb_auto = ~hb_auto;
    end
  end

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 32'(attempt_count), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("result_code", 32'(result_code), 32'(e.code));
          check("pulse_width", 32'(pulse_width), 32'(e.pw));
          check("attempt_count", 32'(attempt_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lowcnt;
    rst_n     = 1'b0;
    glitch_in = 1'b1;
    target_ok = 1'b0;
    hb_manual = 1'b0;
    hb_en     = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_code", 32'(result_code), 0);
    check("rst_pw", 32'(pulse_width), 0);
    check("rst_count", 32'(attempt_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // NORMAL with timing check from glitch release to strobe
    hb_en = 1'b1;
    push(2'b00, 16'd36, 16'd1);
    pulse(36);
    wait_valid(200, cyc);
    check("normal_latency", 32'(cyc), 32'd103);
    repeat (10) @(negedge clk);

    // MUTE
    hb_en = 1'b0;
    push(2'b10, 16'd36, 16'd2);
    pulse(36);
    repeat (10) @(negedge clk);
    check("observe_busy", 32'(busy), 1);
    wait_valid(200, cyc);
    check("mute_seen", 32'(cyc > 0), 1);
    repeat (10) @(negedge clk);
    check("idle_after_report", 32'(busy), 0);

    // DEGRADED: exactly one heartbeat edge inside the window
    push(2'b01, 16'd36, 16'd3);
    pulse(36);
    repeat (30) @(negedge clk);
    hb_manual = ~hb_manual;
    wait_valid(200, cyc);
    check("degraded_seen", 32'(cyc > 0), 1);
    repeat (10) @(negedge clk);

    // SUCCESS: one-cycle ok pulse mid-window while heartbeat runs
    hb_en = 1'b1;
    push(2'b11, 16'd36, 16'd4);
    pulse(36);
    repeat (52) @(negedge clk);
    target_ok = 1'b1;
    @(negedge clk);
    target_ok = 1'b0;
    wait_valid(200, cyc);
    check("success_seen", 32'(cyc > 0), 1);
    repeat (10) @(negedge clk);

`ifndef GLITCH_MON_STICKY_EN
    // Window truncated by a new falling edge; second pulse measured in full
    push(2'b00, 16'd20, 16'd5);
    push(2'b00, 16'd25, 16'd6);
    pulse(20);
    repeat (43) @(negedge clk);
    glitch_in = 1'b0;
    lowcnt = 0;
    cyc = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      lowcnt++;
      if (result_valid) begin
        cyc = i;
        break;
      end
    end
    check("trunc_latency_le3", 32'((cyc > 0) && (cyc <= 3)), 1);
    @(negedge clk);
    lowcnt++;
    check("trunc_back_to_pulse", 32'(busy), 1);
    check("trunc_valid_1cyc", 32'(result_valid), 0);
    repeat (25 - lowcnt) @(negedge clk);
    glitch_in = 1'b1;
    wait_valid(200, cyc);
    check("second_result_seen", 32'(cyc > 0), 1);
    repeat (10) @(negedge clk);

    // Width saturation
    push(2'b00, 16'hFFFF, 16'd7);
    pulse(70000);
    wait_valid(200, cyc);
    check("sat_seen", 32'(cyc > 0), 1);
    repeat (10) @(negedge clk);
`endif

    // Reset in the middle of the observation window discards the attempt
    pulse(36);
    repeat (62) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_valid", 32'(result_valid), 0);
    check("midrst_code", 32'(result_code), 0);
    check("midrst_pw", 32'(pulse_width), 0);
    check("midrst_count", 32'(attempt_count), 0);
    check("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("midrst_count_after", 32'(attempt_count), 0);

`ifdef GLITCH_MON_STICKY_EN
    check("sticky_after_rst", 32'(success_latched), 0);
    push(2'b11, 16'd36, 16'd1);
    pulse(36);
    repeat (52) @(negedge clk);
    target_ok = 1'b1;
    @(negedge clk);
    target_ok = 1'b0;
    wait_valid(200, cyc);
    check("sticky_success_seen", 32'(cyc > 0), 1);
    @(negedge clk);
    check("sticky_set", 32'(success_latched), 1);
    pulse(30);
    repeat (150) @(negedge clk);
    check("sticky_busy", 32'(busy), 0);
    check("sticky_code", 32'(result_code), 32'd3);
    check("sticky_pw", 32'(pulse_width), 32'd36);
    check("sticky_count", 32'(attempt_count), 32'd1);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
